// File: rtl/prefix_sub_pkg.sv
// Shared definitions for the prefix subtractor: level count, the P/G bundle
// type, the folded carry-in constant and the Kogge-Stone combine cell.
package prefix_sub_pkg;

    // The carry-in of a + ~b + 1, folded into bit 0 as G[-1].
    localparam logic CIN = 1'b1;

    // Width of the default build; pg_t describes one stage of that build.
    localparam int DEFAULT_WIDTH = 16;

    // Group propagate and generate vectors for one prefix level.
    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] p;
        logic [DEFAULT_WIDTH-1:0] g;
    } pg_t;

    // Number of Kogge-Stone levels needed to span a word of the given width.
    function automatic int prefix_levels(input int width);
        int levels;
        levels = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < width) begin
                levels = i + 1;
            end
        end
        return levels;
    endfunction

    // Prefix combine: {P, G} of the upper group merged with the lower group.
    function automatic logic [1:0] pg_combine(input logic p_hi, input logic g_hi,
                                              input logic p_lo, input logic g_lo);
        return {p_hi & p_lo, g_hi | (p_hi & g_lo)};
    endfunction

endpackage

// File: rtl/prefix_sub_stage.sv
// One registered Kogge-Stone level of span SPAN, with its own valid bit.
// The raw per-bit propagate rides along unchanged for the final sum.
module prefix_sub_stage
    import prefix_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SPAN  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_p,
    input  logic [WIDTH-1:0] up_gp,
    input  logic [WIDTH-1:0] up_gg,
    input  logic             down_ready,
    output logic             valid,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] gp,
    output logic [WIDTH-1:0] gg
);

    logic             advance;
    logic [WIDTH-1:0] next_gp;
    logic [WIDTH-1:0] next_gg;

    // A stage may load when it is empty or its content moves on this cycle.
    assign advance = ~valid | down_ready;

    // Merge each group with the one SPAN bits below; low bits pass through.
    always_comb begin
        next_gp = up_gp;
        next_gg = up_gg;
        for (int i = SPAN; i < WIDTH; i++) begin
            {next_gp[i], next_gg[i]} = pg_combine(up_gp[i], up_gg[i],
                                                  up_gp[i-SPAN], up_gg[i-SPAN]);
        end
    end

    // Occupancy flag; the only state in the stage that is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (advance) begin
            valid <= up_valid;
        end
    end

    // Datapath registers, meaningful only while valid is set.
    always_ff @(posedge clk) begin
        if (advance) begin
            p  <= up_p;
            gp <= next_gp;
            gg <= next_gg;
        end
    end

endmodule

// File: rtl/prefix_sub_pipe.sv
// Pipelined valid/ready unsigned subtractor, diff = a - b, built as
// a + ~b + 1 on a Kogge-Stone prefix tree with one level per stage.
// Optional macro PREFIX_SUB_SAT_EN clamps diff to zero on borrow.
module prefix_sub_pipe
    import prefix_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             equal
);

    localparam int LEVELS = prefix_levels(WIDTH);

    logic             vld   [LEVELS+1];
    logic [WIDTH-1:0] raw_p [LEVELS+1];
    logic [WIDTH-1:0] gp    [LEVELS+1];
    logic [WIDTH-1:0] gg    [LEVELS+1];

    logic [LEVELS+1:0] occupied;
    logic [LEVELS+1:0] ready;

    logic [WIDTH-1:0] in_p;
    logic [WIDTH-1:0] in_g;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum;
    logic             borrow_next;
    logic             equal_next;

    // Gather occupancy of every register stage, output stage on top.
    always_comb begin
        occupied = '0;
        for (int k = 0; k <= LEVELS; k++) begin
            occupied[k] = vld[k];
        end
        occupied[LEVELS+1] = out_valid;
    end

    // Ready chain ~v_k | ready_(k+1), unrolled so each term reads only flops.
    for (genvar k = 0; k <= LEVELS + 1; k++) begin : g_ready
        assign ready[k] = ~(&occupied[LEVELS+1:k]) | out_ready;
    end

    assign in_ready = ready[0];

    // Per-bit propagate/generate of a + ~b, carry-in folded into bit 0.
    always_comb begin
        in_p    = ~(a ^ b);
        in_g    = a & ~b;
        in_g[0] = in_g[0] | (in_p[0] & CIN);
    end

    // Input stage occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld[0] <= 1'b0;
        end else if (ready[0]) begin
            vld[0] <= in_valid;
        end
    end

    // Input stage data: raw propagate plus the level-0 group vectors.
    always_ff @(posedge clk) begin
        if (ready[0]) begin
            raw_p[0] <= in_p;
            gp[0]    <= in_p;
            gg[0]    <= in_g;
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        prefix_sub_stage #(
            .WIDTH (WIDTH),
            .SPAN  (1 << (k - 1))
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .up_valid   (vld[k-1]),
            .up_p       (raw_p[k-1]),
            .up_gp      (gp[k-1]),
            .up_gg      (gg[k-1]),
            .down_ready (ready[k+1]),
            .valid      (vld[k]),
            .p          (raw_p[k]),
            .gp         (gp[k]),
            .gg         (gg[k])
        );
    end

    // Sum bit i uses the carry out of bits i-1..-1; the word carry-out is ~borrow.
    always_comb begin
        carry       = {gg[LEVELS][WIDTH-2:0], CIN};
        sum         = raw_p[LEVELS] ^ carry;
        borrow_next = ~gg[LEVELS][WIDTH-1];
        equal_next  = gp[LEVELS][WIDTH-1];
    end

    // Output register, reset so downstream sees clean zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            equal     <= 1'b0;
        end else if (ready[LEVELS+1]) begin
            out_valid <= vld[LEVELS];
            if (vld[LEVELS]) begin
`ifdef PREFIX_SUB_SAT_EN
                diff <= borrow_next ? '0 : sum;
`else
                diff <= sum;
`endif
                borrow <= borrow_next;
                equal  <= equal_next;
            end
        end
    end

endmodule

// File: tb/tb_prefix_sub_pipe.sv
// Directed and random checks for prefix_sub_pipe (WIDTH=16, six stages).
// Expected results follow PREFIX_SUB_SAT_EN when it is defined.
module tb_prefix_sub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] diff;
    logic        borrow;
    logic        equal;

    int total = 0;
    int bad = 0;

    prefix_sub_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .equal     (equal)
    );

    always #5 clk = ~clk;

    // Reference: {diff, borrow, equal}.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] d;
        d = x - y;
`ifdef PREFIX_SUB_SAT_EN
        if (x < y) d = 16'h0000;
`endif
        return {d, x < y, x == y};
    endfunction

    task automatic test_reset;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({out_valid, diff, borrow, equal} !== 19'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got v=%b d=%h b=%b e=%b, want all zero",
                     out_valid, diff, borrow, equal);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic [17:0] ve [5];
        int cyc;
        va[0] = 16'h0005; vb[0] = 16'h0003; ve[0] = {16'h0002, 1'b0, 1'b0};
`ifdef PREFIX_SUB_SAT_EN
        va[1] = 16'h0003; vb[1] = 16'h0005; ve[1] = {16'h0000, 1'b1, 1'b0};
`else
        va[1] = 16'h0003; vb[1] = 16'h0005; ve[1] = {16'hFFFE, 1'b1, 1'b0};
`endif
        va[2] = 16'h8000; vb[2] = 16'h0001; ve[2] = {16'h7FFF, 1'b0, 1'b0};
        va[3] = 16'h1234; vb[3] = 16'h1234; ve[3] = {16'h0000, 1'b0, 1'b1};
`ifdef PREFIX_SUB_SAT_EN
        va[4] = 16'h0000; vb[4] = 16'hFFFF; ve[4] = {16'h0000, 1'b1, 1'b0};
`else
        va[4] = 16'h0000; vb[4] = 16'hFFFF; ve[4] = {16'h0001, 1'b1, 1'b0};
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = va[i];
            b = vb[i];
            in_valid = 1'b1;
            out_ready = 1'b1;
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("[TB] FAIL basic_in_ready[%0d]: got %b want 1", i, in_ready);
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
            cyc = 1;
            @(negedge clk);
            while (out_valid !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            total++;
            if (cyc !== 6) begin
                bad++;
                $display("[TB] FAIL basic_latency[%0d]: got %0d cycles want 6", i, cyc);
            end
            total++;
            if ({diff, borrow, equal} !== ve[i]) begin
                bad++;
                $display("[TB] FAIL basic_result[%0d]: got d=%h b=%b e=%b want d=%h b=%b e=%b",
                         i, diff, borrow, equal, ve[i][17:2], ve[i][1], ve[i][0]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] pa [10];
        logic [15:0] pb [10];
        logic [17:0] e;
        int sent, recv, drain_cycles;
        logic release_out;
        for (int i = 0; i < 10; i++) begin
            pa[i] = 16'h1000 + 16'(i * 16'h0123);
            pb[i] = (i % 2 == 1) ? pa[i] + 16'd5 : pa[i] - 16'd7;
        end
        sent = 0;
        recv = 0;
        drain_cycles = 0;
        release_out = 1'b0;
        for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
            @(negedge clk);
            out_ready = release_out;
            in_valid = (sent < 10);
            if (sent < 10) begin
                a = pa[sent];
                b = pb[sent];
            end
            #1;
            if (out_ready) begin
                drain_cycles++;
                if (out_valid) begin
                    e = model(pa[recv], pb[recv]);
                    total++;
                    if ({diff, borrow, equal} !== e) begin
                        bad++;
                        $display("[TB] FAIL bp_result[%0d]: got d=%h b=%b e=%b want d=%h b=%b e=%b",
                                 recv, diff, borrow, equal, e[17:2], e[1], e[0]);
                    end
                    recv++;
                end
            end
            if (in_valid && in_ready) begin
                sent++;
            end else if (in_valid && !release_out) begin
                total++;
                if (sent !== 6) begin
                    bad++;
                    $display("[TB] FAIL bp_capacity: in_ready fell after %0d accepts want 6", sent);
                end
                release_out = 1'b1;
            end
        end
        in_valid = 1'b0;
        total++;
        if (release_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bp_stall: in_ready never fell with out_ready low");
        end
        total++;
        if (recv !== 10) begin
            bad++;
            $display("[TB] FAIL bp_count: got %0d results want 10", recv);
        end
        total++;
        if (drain_cycles !== 10) begin
            bad++;
            $display("[TB] FAIL bp_rate: drain took %0d cycles want 10", drain_cycles);
        end
    endtask

    task automatic test_reset_midflight;
        int spurious, cyc;
        logic [17:0] e;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 16'h0400 + 16'(i);
            b = 16'h0100;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_inflight: got out_valid=%b want 1 before reset", out_valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_reset_valid: got %b want 0", out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        spurious = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b0) spurious++;
        end
        total++;
        if (spurious !== 0) begin
            bad++;
            $display("[TB] FAIL mid_stale: got %0d stale results want 0", spurious);
        end
        a = 16'h00FF;
        b = 16'h0100;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc !== 6) begin
            bad++;
            $display("[TB] FAIL mid_latency: got %0d cycles want 6", cyc);
        end
`ifdef PREFIX_SUB_SAT_EN
        e = {16'h0000, 1'b1, 1'b0};
`else
        e = {16'hFFFF, 1'b1, 1'b0};
`endif
        total++;
        if ({diff, borrow, equal} !== e) begin
            bad++;
            $display("[TB] FAIL mid_result: got d=%h b=%b e=%b want d=%h b=%b e=%b",
                     diff, borrow, equal, e[17:2], e[1], e[0]);
        end
    endtask

    task automatic test_random;
        logic [17:0] exp_q [$];
        logic [17:0] e;
        int acc, cyc;
        acc = 0;
        cyc = 0;
        @(negedge clk);
        while ((acc < 10000 || exp_q.size() > 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            in_valid = (acc < 10000) && ($urandom_range(3) != 0);
            a = 16'($urandom);
            b = ($urandom_range(7) == 0) ? a : 16'($urandom);
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL rnd_spurious: got d=%h with no pending pair", diff);
                end else begin
                    e = exp_q.pop_front();
                    if ({diff, borrow, equal} !== e) begin
                        bad++;
                        $display("[TB] FAIL rnd_result: got d=%h b=%b e=%b want d=%h b=%b e=%b",
                                 diff, borrow, equal, e[17:2], e[1], e[0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b));
                acc++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (acc !== 10000 || exp_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL rnd_timeout: accepted %0d pending %0d want 10000 and 0",
                     acc, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
